// File: rtl/rtc_pkg.sv
// rtc_pkg: shared constants, types and helpers for the rtc_timer slice.
//   - Register address map (low address byte only).
//   - Field limits and the alarm-disable code.
//   - Time-of-day struct, one-second carry helper and address decoder.
package rtc_pkg;

    localparam logic [7:0] RTC_ADDR_SEC        = 8'h00;
    localparam logic [7:0] RTC_ADDR_MIN        = 8'h01;
    localparam logic [7:0] RTC_ADDR_HOUR       = 8'h02;
    localparam logic [7:0] RTC_ADDR_ACLR       = 8'h03;
    localparam logic [7:0] RTC_ADDR_ALARM_BASE = 8'h10;

    localparam logic [7:0] SEC_MAX   = 8'd59;
    localparam logic [7:0] MIN_MAX   = 8'd59;
    localparam logic [7:0] HOUR_MAX  = 8'd23;
    localparam logic [7:0] ALARM_OFF = 8'hFF;

    typedef enum logic [2:0] {
        FLD_NONE,
        FLD_SEC,
        FLD_MIN,
        FLD_HOUR,
        FLD_ACLR,
        FLD_AMIN,
        FLD_AHOUR
    } rtc_field_e;

    typedef struct packed {
        logic [7:0] hour;
        logic [7:0] minute;
        logic [7:0] second;
    } rtc_time_t;

    // Advance the time of day by one second, carrying into minute and hour.
    function automatic rtc_time_t rtc_advance(input rtc_time_t cur);
        rtc_time_t nxt;
        nxt = cur;
        if (cur.second == SEC_MAX) begin
            nxt.second = '0;
            if (cur.minute == MIN_MAX) begin
                nxt.minute = '0;
                nxt.hour   = (cur.hour == HOUR_MAX) ? '0 : cur.hour + 8'd1;
            end else begin
                nxt.minute = cur.minute + 8'd1;
            end
        end else begin
            nxt.second = cur.second + 8'd1;
        end
        return nxt;
    endfunction

    // Map an address byte to the register it selects. Alarm channel k
    // occupies 0x10+2k (minute) and 0x11+2k (hour); channels beyond
    // n_alarms decode as unmapped.
    function automatic rtc_field_e rtc_decode(input logic [7:0] a,
                                              input int unsigned n_alarms);
        rtc_field_e f;
        f = FLD_NONE;
        case (a)
            RTC_ADDR_SEC:  f = FLD_SEC;
            RTC_ADDR_MIN:  f = FLD_MIN;
            RTC_ADDR_HOUR: f = FLD_HOUR;
            RTC_ADDR_ACLR: f = FLD_ACLR;
            default: begin
                if ((a[7:4] == RTC_ADDR_ALARM_BASE[7:4]) &&
                    (32'(a[3:1]) < n_alarms)) begin
                    f = a[0] ? FLD_AHOUR : FLD_AMIN;
                end
            end
        endcase
        return f;
    endfunction

endpackage

// File: rtl/rtc_wr_sync.sv
// rtc_wr_sync: brings the asynchronous CPU write interface into the
// clock domain and turns each qualified rising edge of w_n into a
// single-cycle write request.
//   clock, rst_n : system clock, synchronous active-low reset
//   w_n          : asynchronous write strobe (rising edge commits)
//   w_en_n       : write enable, active-low, qualifies w_n
//   t, addr      : write data and low address byte
//   wr           : one-cycle write request
//   wr_addr      : synchronised address byte
//   wr_data      : synchronised write data
module rtc_wr_sync
    import rtc_pkg::*;
(
    input  logic       clock,
    input  logic       rst_n,
    input  logic       w_n,
    input  logic       w_en_n,
    input  logic [7:0] t,
    input  logic [7:0] addr,
    output logic       wr,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data
);

    logic       r_w_n_s1;
    logic       r_w_n_s2;
    logic       r_w_n_s3;
    logic       r_w_en_n_s1;
    logic       r_w_en_n_s2;
    logic [7:0] r_t_s1;
    logic [7:0] r_t_s2;
    logic [7:0] r_addr_s1;
    logic [7:0] r_addr_s2;

    // Strobe stages reset high so that a strobe idling high after reset
    // never looks like a rising edge.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_w_n_s1    <= 1'b1;
            r_w_n_s2    <= 1'b1;
            r_w_n_s3    <= 1'b1;
            r_w_en_n_s1 <= 1'b1;
            r_w_en_n_s2 <= 1'b1;
            r_t_s1      <= '0;
            r_t_s2      <= '0;
            r_addr_s1   <= '0;
            r_addr_s2   <= '0;
        end else begin
            r_w_n_s1    <= w_n;
            r_w_n_s2    <= r_w_n_s1;
            r_w_n_s3    <= r_w_n_s2;
            r_w_en_n_s1 <= w_en_n;
            r_w_en_n_s2 <= r_w_en_n_s1;
            r_t_s1      <= t;
            r_t_s2      <= r_t_s1;
            r_addr_s1   <= addr;
            r_addr_s2   <= r_addr_s1;
        end
    end

    assign wr      = r_w_n_s2 && !r_w_n_s3 && !r_w_en_n_s2;
    assign wr_addr = r_addr_s2;
    assign wr_data = r_t_s2;

endmodule

// File: rtl/rtc_timer.sv
// rtc_timer: 24-hour time-of-day counter with CPU-writable fields and
// NUM_ALARMS hour:minute alarm channels with sticky flags.
//   CLK_FREQ   : clock cycles per second (>= 2)
//   NUM_ALARMS : alarm channels (1..8)
//   clock, rst_n         : system clock, synchronous active-low reset
//   w_n, w_en_n, t, addr : asynchronous CPU write port (addr[7:0] decoded)
//   hour, minute, second : current time
//   alarm                : sticky alarm flags, one per channel
//   sec_pulse            : high in the cycle a new second value appears
module rtc_timer
    import rtc_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 10_000_000,
    parameter int unsigned NUM_ALARMS = 2
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  w_n,
    input  logic                  w_en_n,
    input  logic [7:0]            t,
    input  logic [15:0]           addr,
    output logic [7:0]            hour,
    output logic [7:0]            minute,
    output logic [7:0]            second,
    output logic [NUM_ALARMS-1:0] alarm,
    output logic                  sec_pulse
);

    localparam int unsigned          CNT_W    = $clog2(CLK_FREQ);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(CLK_FREQ - 1);

    logic             w_wr;
    logic [7:0]       w_wr_addr;
    logic [7:0]       w_wr_data;
    logic             w_unused_addr_hi;
    rtc_field_e       w_field;
    logic             w_wr_sec;
    logic             w_wr_min;
    logic             w_wr_hour;
    logic             w_tick;
    rtc_time_t        w_adv;
    rtc_time_t        w_next;

    rtc_time_t        r_time;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pulse;

    assign w_unused_addr_hi = ^addr[15:8];

    rtc_wr_sync u_wr_sync (
        .clock   (clock),
        .rst_n   (rst_n),
        .w_n     (w_n),
        .w_en_n  (w_en_n),
        .t       (t),
        .addr    (addr[7:0]),
        .wr      (w_wr),
        .wr_addr (w_wr_addr),
        .wr_data (w_wr_data)
    );

    // The tick advances all fields first; an accepted write then overrides
    // only its own field, so carries still reach the fields not written.
    // An accepted second write restarts the prescaler and swallows the tick.
    always_comb begin
        w_field   = w_wr ? rtc_decode(w_wr_addr, NUM_ALARMS) : FLD_NONE;
        w_wr_sec  = (w_field == FLD_SEC)  && (w_wr_data <= SEC_MAX);
        w_wr_min  = (w_field == FLD_MIN)  && (w_wr_data <= MIN_MAX);
        w_wr_hour = (w_field == FLD_HOUR) && (w_wr_data <= HOUR_MAX);
        w_tick    = (r_cnt == CNT_LAST) && !w_wr_sec;
        w_adv     = w_tick ? rtc_advance(r_time) : r_time;
        w_next    = w_adv;
        if (w_wr_sec)  w_next.second = w_wr_data;
        if (w_wr_min)  w_next.minute = w_wr_data;
        if (w_wr_hour) w_next.hour   = w_wr_data;
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_time  <= '0;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_time  <= w_next;
            r_pulse <= w_tick;
            if (w_wr_sec || (r_cnt == CNT_LAST)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign hour      = r_time.hour;
    assign minute    = r_time.minute;
    assign second    = r_time.second;
    assign sec_pulse = r_pulse;

    for (genvar k = 0; k < NUM_ALARMS; k++) begin : g_alarm
        logic [7:0] r_amin;
        logic [7:0] r_ahour;
        logic       r_flag;
        logic       w_sel;
        logic       w_set_min;
        logic       w_set_hour;
        logic       w_clr;
        logic       w_hit;

        assign w_sel      = (w_wr_addr[3:1] == 3'(k));
        assign w_set_min  = (w_field == FLD_AMIN) && w_sel && (w_wr_data <= MIN_MAX);
        assign w_set_hour = (w_field == FLD_AHOUR) && w_sel &&
                            ((w_wr_data <= HOUR_MAX) || (w_wr_data == ALARM_OFF));
        assign w_clr      = (w_field == FLD_ACLR) && w_wr_data[k];
        // Matched against the tick-only time so CPU time writes never fire;
        // a disabled hour (0xFF) can never equal a valid hour.
        assign w_hit      = w_tick && (w_adv.second == '0) &&
                            (w_adv.minute == r_amin) && (w_adv.hour == r_ahour);

        always_ff @(posedge clock) begin
            if (!rst_n) begin
                r_amin  <= '0;
                r_ahour <= ALARM_OFF;
                r_flag  <= 1'b0;
            end else begin
                if (w_set_min)  r_amin  <= w_wr_data;
                if (w_set_hour) r_ahour <= w_wr_data;
                if (w_hit) begin
                    r_flag <= 1'b1;
                end else if (w_clr) begin
                    r_flag <= 1'b0;
                end
            end
        end

        assign alarm[k] = r_flag;
    end

endmodule

// File: tb/tb_rtc_timer.sv
module tb_rtc_timer;

    localparam int CF = 4;
    localparam int NA = 2;
    localparam int VW = 25 + NA;

    logic          clock  = 1'b0;
    logic          rst_n  = 1'b0;
    logic          w_n    = 1'b1;
    logic          w_en_n = 1'b1;
    logic [7:0]    t      = '0;
    logic [15:0]   addr   = '0;
    logic [7:0]    hour;
    logic [7:0]    minute;
    logic [7:0]    second;
    logic [NA-1:0] alarm;
    logic          sec_pulse;

    rtc_timer #(.CLK_FREQ(CF), .NUM_ALARMS(NA)) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .w_n       (w_n),
        .w_en_n    (w_en_n),
        .t         (t),
        .addr      (addr),
        .hour      (hour),
        .minute    (minute),
        .second    (second),
        .alarm     (alarm),
        .sec_pulse (sec_pulse)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: time of day as seconds since midnight, a phase
    // counter within the second, and alarm settings as plain integers.
    int       edge_no = 0;
    int       m_tod   = 0;
    int       m_cnt   = 0;
    int       m_pulse = 0;
    bit [NA-1:0] m_flags = '0;
    int       m_ah [NA];
    int       m_am [NA];
    bit       pend = 1'b0;
    int       pend_edge, pend_addr, pend_data;
    bit       pend_en_n;
    bit       mv_do_wr, mv_sec_wr, mv_tick;
    int       mv_tod, mv_h, mv_m, mv_s, mv_ch;
    bit [NA-1:0] mv_set, mv_clr;

    always @(posedge clock) begin
        edge_no++;
        mv_do_wr = pend && (edge_no == pend_edge) && !pend_en_n;
        if (pend && (edge_no == pend_edge)) pend = 1'b0;
        if (!rst_n) begin
            m_tod = 0; m_cnt = 0; m_pulse = 0; m_flags = '0; pend = 1'b0;
            for (int k = 0; k < NA; k++) begin m_ah[k] = 255; m_am[k] = 0; end
        end else begin
            mv_sec_wr = mv_do_wr && (pend_addr == 0) && (pend_data <= 59);
            mv_tick   = (m_cnt == CF - 1) && !mv_sec_wr;
            mv_tod    = mv_tick ? (m_tod + 1) % 86400 : m_tod;
            mv_set    = '0;
            mv_clr    = '0;
            for (int k = 0; k < NA; k++)
                if (mv_tick && (mv_tod % 60 == 0) && (m_ah[k] != 255) &&
                    (mv_tod / 60 == m_ah[k] * 60 + m_am[k]))
                    mv_set[k] = 1'b1;
            mv_h = mv_tod / 3600;
            mv_m = (mv_tod / 60) % 60;
            mv_s = mv_tod % 60;
            if (mv_do_wr) begin
                if (pend_addr == 0 && pend_data <= 59) mv_s = pend_data;
                else if (pend_addr == 1 && pend_data <= 59) mv_m = pend_data;
                else if (pend_addr == 2 && pend_data <= 23) mv_h = pend_data;
                else if (pend_addr == 3) mv_clr = pend_data[NA-1:0];
                else if (pend_addr >= 16 && pend_addr < 16 + 2 * NA) begin
                    mv_ch = (pend_addr - 16) / 2;
                    if (pend_addr % 2 == 0) begin
                        if (pend_data <= 59) m_am[mv_ch] = pend_data;
                    end else if (pend_data <= 23 || pend_data == 255) begin
                        m_ah[mv_ch] = pend_data;
                    end
                end
            end
            m_tod   = mv_h * 3600 + mv_m * 60 + mv_s;
            m_cnt   = mv_sec_wr ? 0 : (m_cnt + 1) % CF;
            m_pulse = mv_tick ? 1 : 0;
            m_flags = (m_flags & ~mv_clr) | mv_set;
        end
    end

    function automatic logic [VW-1:0] exp_vec();
        return {8'(m_tod / 3600), 8'((m_tod / 60) % 60), 8'(m_tod % 60), m_flags, 1'(m_pulse)};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clock); rst_n = 1'b0;
        @(negedge clock); rst_n = 1'b1;
    endtask

    // One CPU write. Optionally delays the rising edge so the write lands on
    // the edge whose pre-edge prescaler phase is align_cnt (and, if
    // align_sec >= 0, while the seconds field reads align_sec). Returns at
    // the falling edge after the write has taken effect.
    task automatic wr_reg(input int a, input int d, input bit en_n,
                          input int align_cnt, input int align_sec);
        int guard;
        @(negedge clock); w_n = 1'b0;
        repeat (2) @(negedge clock);
        addr = {8'($urandom_range(0, 255)), 8'(a)};
        t = 8'(d);
        w_en_n = en_n;
        @(negedge clock);
        guard = 0;
        while (align_cnt >= 0 && guard < 2000 &&
               !((((m_cnt + 2) % CF) == align_cnt) && (align_sec < 0 || (m_tod % 60) == align_sec))) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 2000) begin
            n_checks++;
            $display("FAIL align_timeout: waited %0d cycles, required < 2000", guard);
        end
        w_n = 1'b1;
        pend = 1'b1; pend_edge = edge_no + 3; pend_addr = a; pend_data = d; pend_en_n = en_n;
        repeat (3) @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        rst_n = 1'b1;
        n_checks++;
        if ({hour, minute, second, alarm, sec_pulse} !== '0)
            $display("FAIL reset_outputs: got %h required 0", {hour, minute, second, alarm, sec_pulse});
        else n_pass++;
        @(negedge clock);
        n_checks++;
        if ({hour, minute, second, alarm, sec_pulse} !== exp_vec())
            $display("FAIL reset_model: got %h required %h", {hour, minute, second, alarm, sec_pulse}, exp_vec());
        else n_pass++;
    endtask

    task automatic test_runthrough();
        int pulses, last;
        apply_reset();
        pulses = 0; last = 0;
        for (int i = 1; i <= 240; i++) begin
            @(negedge clock);
            n_checks++;
            if ({hour, minute, second, alarm, sec_pulse} !== exp_vec())
                $display("FAIL run_model c%0d: got %h required %h", i, {hour, minute, second, alarm, sec_pulse}, exp_vec());
            else n_pass++;
            if (sec_pulse === 1'b1) begin
                pulses++;
                n_checks++;
                if (i - last != CF) $display("FAIL run_period: got %0d cycles required %0d", i - last, CF);
                else n_pass++;
                last = i;
            end
        end
        n_checks++;
        if ({hour, minute, second} !== {8'd0, 8'd1, 8'd0})
            $display("FAIL run_time: got %0d:%0d:%0d required 0:1:0", hour, minute, second);
        else n_pass++;
        n_checks++;
        if (pulses != 60) $display("FAIL run_pulses: got %0d required 60", pulses);
        else n_pass++;
    endtask

    task automatic test_day_wrap();
        int pulses;
        apply_reset();
        wr_reg(2, 23, 1'b0, -1, -1);
        wr_reg(1, 59, 1'b0, -1, -1);
        wr_reg(0, 59, 1'b0, -1, -1);
        n_checks++;
        if ({hour, minute, second} !== {8'd23, 8'd59, 8'd59})
            $display("FAIL wrap_set: got %0d:%0d:%0d required 23:59:59", hour, minute, second);
        else n_pass++;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (sec_pulse === 1'b1) pulses++;
            n_checks++;
            if ({hour, minute, second, alarm, sec_pulse} !== exp_vec())
                $display("FAIL wrap_model: got %h required %h", {hour, minute, second, alarm, sec_pulse}, exp_vec());
            else n_pass++;
        end
        n_checks++;
        if ({hour, minute, second, alarm} !== '0 || pulses != 1)
            $display("FAIL wrap_result: got %0d:%0d:%0d alarm %b pulses %0d required 0:0:0 alarm 0 pulses 1",
                     hour, minute, second, alarm, pulses);
        else n_pass++;
    endtask

    task automatic test_collision();
        int first;
        apply_reset();
        wr_reg(2, 5, 1'b0, -1, -1);
        wr_reg(1, 7, 1'b0, -1, -1);
        wr_reg(0, 50, 1'b0, -1, -1);
        wr_reg(1, 30, 1'b0, CF - 1, 59);
        n_checks++;
        if ({hour, minute, second, sec_pulse} !== {8'd5, 8'd30, 8'd0, 1'b1})
            $display("FAIL collide_time: got %0d:%0d:%0d p%b required 5:30:0 p1", hour, minute, second, sec_pulse);
        else n_pass++;
        n_checks++;
        if ({hour, minute, second, alarm, sec_pulse} !== exp_vec())
            $display("FAIL collide_model: got %h required %h", {hour, minute, second, alarm, sec_pulse}, exp_vec());
        else n_pass++;
        wr_reg(0, 10, 1'b0, 1, -1);
        n_checks++;
        if (second !== 8'd10) $display("FAIL secwr_value: got %0d required 10", second);
        else n_pass++;
        first = 0;
        for (int j = 1; j <= 8 && first == 0; j++) begin
            @(negedge clock);
            if (sec_pulse === 1'b1) first = j;
        end
        n_checks++;
        if (first != 4 || second !== 8'd11)
            $display("FAIL secwr_restart: got pulse after %0d cycles second %0d required 4 and 11", first, second);
        else n_pass++;
    endtask

    task automatic test_range();
        apply_reset();
        wr_reg(2, 7, 1'b0, -1, -1);
        wr_reg(1, 20, 1'b0, -1, -1);
        wr_reg(2, 24, 1'b0, -1, -1);
        wr_reg(1, 60, 1'b0, -1, -1);
        wr_reg(0, 60, 1'b0, -1, -1);
        wr_reg(5, 3, 1'b0, -1, -1);
        wr_reg(2, 9, 1'b1, -1, -1);
        n_checks++;
        if ({hour, minute} !== {8'd7, 8'd20})
            $display("FAIL range_hold: got %0d:%0d required 7:20", hour, minute);
        else n_pass++;
        n_checks++;
        if ({hour, minute, second, alarm, sec_pulse} !== exp_vec())
            $display("FAIL range_model: got %h required %h", {hour, minute, second, alarm, sec_pulse}, exp_vec());
        else n_pass++;
    endtask

    task automatic test_alarms();
        int waited;
        apply_reset();
        wr_reg(16, 1, 1'b0, -1, -1);
        wr_reg(17, 0, 1'b0, -1, -1);
        wr_reg(18, 2, 1'b0, -1, -1);
        wr_reg(19, 0, 1'b0, -1, -1);
        wr_reg(19, 254, 1'b0, -1, -1);
        waited = 0;
        do begin
            @(negedge clock);
            waited++;
        end while (alarm === '0 && waited < 400);
        n_checks++;
        if ({alarm, hour, minute, second, sec_pulse} !== {2'b01, 8'd0, 8'd1, 8'd0, 1'b1})
            $display("FAIL alarm0_fire: got alarm %b at %0d:%0d:%0d required 01 at 0:1:0", alarm, hour, minute, second);
        else n_pass++;
        wr_reg(3, 3, 1'b0, CF - 1, 59);
        n_checks++;
        if ({alarm, minute, second} !== {2'b10, 8'd2, 8'd0})
            $display("FAIL alarm_setwins: got alarm %b at %0d:%0d required 10 at 2:0", alarm, minute, second);
        else n_pass++;
        n_checks++;
        if ({hour, minute, second, alarm, sec_pulse} !== exp_vec())
            $display("FAIL alarm_model: got %h required %h", {hour, minute, second, alarm, sec_pulse}, exp_vec());
        else n_pass++;
        wr_reg(3, 3, 1'b0, -1, -1);
        wr_reg(19, 255, 1'b0, -1, -1);
        wr_reg(1, 1, 1'b0, -1, -1);
        wr_reg(0, 0, 1'b0, -1, -1);
        n_checks++;
        if ({alarm, minute, second} !== {2'b00, 8'd1, 8'd0})
            $display("FAIL alarm_cpuwrite: got alarm %b at %0d:%0d required 00 at 1:0", alarm, minute, second);
        else n_pass++;
        wr_reg(0, 59, 1'b0, -1, -1);
        repeat (4) @(negedge clock);
        n_checks++;
        if ({alarm, minute, second} !== {2'b00, 8'd2, 8'd0})
            $display("FAIL alarm_disabled: got alarm %b at %0d:%0d required 00 at 2:0", alarm, minute, second);
        else n_pass++;
    endtask

    task automatic test_random();
        int alist[11] = '{0, 1, 2, 3, 16, 17, 18, 19, 20, 5, 0};
        int idx, a, d, al;
        bit en;
        apply_reset();
        for (int n = 0; n < 30; n++) begin
            idx = $urandom_range(0, 10);
            a = (idx == 10) ? $urandom_range(0, 255) : alist[idx];
            case ($urandom_range(0, 4))
                0: d = $urandom_range(0, 23);
                1: d = $urandom_range(0, 59);
                2: d = $urandom_range(55, 65);
                3: d = 255;
                default: d = $urandom_range(0, 255);
            endcase
            en = ($urandom_range(0, 7) == 0);
            al = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, CF - 1);
            wr_reg(a, d, en, al, -1);
            n_checks++;
            if ({hour, minute, second, alarm, sec_pulse} !== exp_vec())
                $display("FAIL rand_write a%0h d%0h: got %h required %h", a, d, {hour, minute, second, alarm, sec_pulse}, exp_vec());
            else n_pass++;
            repeat ($urandom_range(0, 6)) begin
                @(negedge clock);
                n_checks++;
                if ({hour, minute, second, alarm, sec_pulse} !== exp_vec())
                    $display("FAIL rand_idle: got %h required %h", {hour, minute, second, alarm, sec_pulse}, exp_vec());
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_midop();
        apply_reset();
        wr_reg(2, 3, 1'b0, -1, -1);
        wr_reg(1, 4, 1'b0, -1, -1);
        @(negedge clock); w_n = 1'b0;
        repeat (2) @(negedge clock);
        addr = 16'h0001; t = 8'd33; w_en_n = 1'b0;
        @(negedge clock);
        w_n = 1'b1;
        pend = 1'b1; pend_edge = edge_no + 3; pend_addr = 1; pend_data = 33; pend_en_n = 1'b0;
        @(negedge clock); rst_n = 1'b0;
        @(negedge clock); rst_n = 1'b1;
        n_checks++;
        if ({hour, minute, second, alarm, sec_pulse} !== '0)
            $display("FAIL midreset_outputs: got %h required 0", {hour, minute, second, alarm, sec_pulse});
        else n_pass++;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            n_checks++;
            if ({hour, minute, second, alarm, sec_pulse} !== exp_vec())
                $display("FAIL midreset_model: got %h required %h", {hour, minute, second, alarm, sec_pulse}, exp_vec());
            else n_pass++;
        end
        n_checks++;
        if ({hour, minute} !== '0)
            $display("FAIL midreset_dropped: got %0d:%0d required 0:0", hour, minute);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_runthrough();
        test_day_wrap();
        test_collision();
        test_range();
        test_alarms();
        test_random();
        test_reset_midop();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
